// File: rtl/tag_mem_arbiter.sv
// tag_mem_arbiter
//   Round-robin arbiter that funnels NREQ requesters onto a single memory
//   request port. Reads are single beats and are tracked by an outstanding
//   counter; writes are BEATS-long bursts that lock the port to their owner
//   until the last beat is accepted.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_valid_i/ready_o   per-requester beat handshake
//   req_write_i           per-requester 1 = write burst, 0 = read
//   req_addr_i/wdata_i    packed per-requester address / beat data (slice i = requester i)
//   mem_req_*             muxed request to memory; mem_req_id_o names the granted requester
//   mem_resp_valid_i/id_i read response from memory
//   resp_valid_o          one-hot decode of the response owner (combinational)
module tag_mem_arbiter #(
  parameter int NREQ      = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int BEATS     = 4,
  parameter int MAX_OUTST = 4,
  localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NREQ-1:0]        req_valid_i,
  output logic [NREQ-1:0]        req_ready_o,
  input  logic [NREQ-1:0]        req_write_i,
  input  logic [NREQ*ADDR_W-1:0] req_addr_i,
  input  logic [NREQ*DATA_W-1:0] req_wdata_i,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic                   mem_req_write_o,
  output logic [ADDR_W-1:0]      mem_req_addr_o,
  output logic [DATA_W-1:0]      mem_req_wdata_o,
  output logic [IDW-1:0]         mem_req_id_o,
  input  logic                   mem_resp_valid_i,
  input  logic [IDW-1:0]         mem_resp_id_i,
  output logic [NREQ-1:0]        resp_valid_o
);

  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [IDW-1:0]    owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [OW-1:0]     outst_q, outst_d;

  logic [ADDR_W-1:0] addr_arr_s [NREQ];
  logic [DATA_W-1:0] data_arr_s [NREQ];
  logic [NREQ-1:0]   elig_s;
  logic              found_s;
  logic [IDW-1:0]    win_s;
  logic [IDW-1:0]    sel_s;
  logic              rd_acc_s;

  // Priority pointer always advances to the requester after the one just served.
  function automatic logic [1:0] ptr_after(input logic [IDW-1:0] w);
    return 2'((int'(w) + 1) % NREQ);
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr_s[g] = req_addr_i[g*ADDR_W +: ADDR_W];
    assign data_arr_s[g] = req_wdata_i[g*DATA_W +: DATA_W];
  end

  // Eligibility: reads are held back once the outstanding window is full.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig_s[i] = req_valid_i[i] & (req_write_i[i] | (outst_q < OUTST_MAX));
    end
  end

  // Round-robin search starting at ptr with wrap-around; first hit wins.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found_s && elig_s[IDW'((int'(ptr_q) + k) % NREQ)]) begin
        found_s = 1'b1;
        win_s   = IDW'((int'(ptr_q) + k) % NREQ);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state, grant mux and handshake outputs.
  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    beat_d          = beat_q;
    owner_d         = owner_q;
    addr_d          = addr_q;
    sel_s           = win_s;
    rd_acc_s        = 1'b0;
    req_ready_o     = '0;
    mem_req_valid_o = 1'b0;
    mem_req_write_o = 1'b0;
    mem_req_addr_o  = addr_arr_s[win_s];

    case (state_q)
      ST_IDLE: begin
        sel_s           = win_s;
        mem_req_valid_o = found_s;
        mem_req_write_o = req_write_i[win_s];
        mem_req_addr_o  = addr_arr_s[win_s];
        if (found_s) begin
          req_ready_o[win_s] = mem_req_ready_i;
        end else begin
          req_ready_o = '0;
        end
        if (found_s && mem_req_ready_i) begin
          if (!req_write_i[win_s]) begin
            rd_acc_s = 1'b1;
            ptr_d    = ptr_after(win_s);
          end else if (BEATS == 1) begin
            // A one-beat burst completes on its first accept.
            ptr_d = ptr_after(win_s);
          end else begin
            state_d = ST_BURST;
            owner_d = win_s;
            beat_d  = BW'(1);
            addr_d  = addr_arr_s[win_s];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BURST: begin
        // Locked to the owner; the address is the one captured on beat 0.
        sel_s                = owner_q;
        mem_req_valid_o      = req_valid_i[owner_q];
        mem_req_write_o      = 1'b1;
        mem_req_addr_o       = addr_q;
        req_ready_o[owner_q] = mem_req_ready_i;
        if (req_valid_i[owner_q] && mem_req_ready_i) begin
          if (beat_q == BEAT_LAST) begin
            state_d = ST_IDLE;
            beat_d  = '0;
            ptr_d   = ptr_after(owner_q);
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end else begin
          beat_d = beat_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mem_req_wdata_o = data_arr_s[sel_s];
    mem_req_id_o    = sel_s;
  end

  // Outstanding-read counter: simultaneous issue and response cancel; a
  // response with nothing outstanding is dropped rather than underflowing.
  always_comb begin
    if (rd_acc_s && mem_resp_valid_i) begin
      outst_d = outst_q;
    end else if (rd_acc_s) begin
      outst_d = outst_q + OW'(1);
    end else if (mem_resp_valid_i && (outst_q != '0)) begin
      outst_d = outst_q - OW'(1);
    end else begin
      outst_d = outst_q;
    end
  end

  // Response owner decode.
  always_comb begin
    resp_valid_o = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (mem_resp_valid_i && (mem_resp_id_i == IDW'(i))) begin
        resp_valid_o[i] = 1'b1;
      end else begin
        resp_valid_o[i] = 1'b0;
      end
    end
  end

  // State registers with synchronous reset; reset abandons any open burst.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      beat_q  <= '0;
      owner_q <= '0;
      addr_q  <= '0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      outst_q <= outst_d;
    end
  end

endmodule
